bowling_scorer: RTL and testbench
=================================

Name:
bowling_scorer

Overview:
- Ten-pin bowling game scorer. It records one pin count per roll strobe, up to one game of 21 rolls.
- On request, it walks the ten frames, one frame per clock, and applies strike and spare bonuses.
- It presents the 9-bit game total.
- It is a standalone leaf block. A host drives rolls and then requests the score.

Parameters:
- MAX_ROLLS, 21, roll storage depth (largest possible game).
- NUM_FRAMES, 10, frames scored per game.
- PIN_W, 4, pin_count width.
- SCORE_W, 9, score width (max 300).

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- roll  input  1  roll strobe; each rising clock edge with roll=1 records one roll.
- calculate_score  input  1  level request to compute the game score.
- pin_count  input  4  pins knocked down by this roll, 0..10; sampled when roll=1.
- score  output  9  game total (unsigned).

Behaviour:
- Reset (synchronous, active-high):
  - clears all 21 roll entries to 0, roll_count to 0, score to 0.
  - sets FSM to IDLE.
  - overrides all other inputs in that cycle and aborts any scoring in progress.
- Roll capture, in IDLE only:
  - roll=1 at a clock edge stores pin_count into rolls[roll_count] and increments roll_count.
  - roll held high N cycles records N rolls.
  - pin_count > 10 is stored as 10.
  - rolls beyond MAX_ROLLS are ignored; roll_count saturates at 21.
  - roll is ignored in SCORING and DONE.
- Unrecorded roll entries read as 0, so partial games score as if the remaining rolls were 0.
- FSM states: IDLE, SCORING, DONE.
  - IDLE -> SCORING when calculate_score=1 at a clock edge. That edge clears the accumulator, frame=0, idx=0.
  - SCORING: one frame per cycle. After frame 9 is added, go to DONE.
  - DONE -> IDLE when calculate_score=0. While calculate_score stays 1, remain in DONE and do not rescore.
  - If calculate_score drops during SCORING, scoring still completes; the FSM then passes through DONE to IDLE.
- Frame rule (a, b, c = rolls[idx], rolls[idx+1], rolls[idx+2]; indices beyond 20 read 0):
  - strike, a==10: add 10+b+c; idx+=1.
  - spare, a+b==10: add 10+c; idx+=2.
  - open frame: add a+b; idx+=2.
  - Tenth-frame fill balls are only ever used as bonus terms and are never scored as frames.
- Score output:
  - score is the registered accumulator. It updates each SCORING cycle and is final 10 cycles after the start edge.
  - The final value holds through DONE and IDLE until the next reset or next scoring start.
  - Recording new rolls does not change score.
- Arithmetic: per-frame sum is at most 30 and the total at most 300; use a 9-bit accumulator, no overflow possible.
- Latency: assert calculate_score, then after exactly 10 rising edges score equals the final total.

Decomposition:
- Package bowling_pkg holds:
  - MAX_ROLLS, NUM_FRAMES, STRIKE_PINS=10.
  - the FSM state enum.
  - pin_t (4-bit) and score_t (9-bit) typedefs.
- One combinational sub-module, bowling_frame_eval:
  - inputs a, b, c.
  - outputs frame_points (5-bit) and idx_step (1 or 2).
- Top module holds the roll RAM/registers, roll_count, FSM, idx and the accumulator.

Test Plan:
- Reset, then assert calculate_score for 10 cycles -> score=0.
- Reset; roll 8, then nineteen 0s; score -> 8.
- Reset; roll 5,5,5, then seventeen 0s; score -> 20 (spare bonus).
- Reset; roll 10,3,4, then sixteen 0s; score -> 24 (strike bonus).
- Reset; twelve rolls of 10; score -> 300. Hold calculate_score 20 cycles -> score stays 300. Reset -> score 0.
- Reset mid-scoring, after 3 rolls of 4 and 5 scoring cycles -> score=0 next cycle; rescore after new rolls of twenty 1s -> 20.

Source files
------------

// File: rtl/bowling_pkg.sv
// bowling_pkg: shared sizes, pin/score types and scorer FSM states
package bowling_pkg;
    localparam int MAX_ROLLS   = 21;
    localparam int NUM_FRAMES  = 10;
    localparam int STRIKE_PINS = 10;
    localparam int PIN_W       = 4;
    localparam int SCORE_W     = 9;
    typedef logic [PIN_W-1:0]   pin_t;
    typedef logic [SCORE_W-1:0] score_t;
    typedef enum logic [1:0] {IDLE, SCORING, DONE} state_t;
endpackage

// File: rtl/bowling_frame_eval.sv
// bowling_frame_eval: points and roll advance for one frame from its three candidate rolls
module bowling_frame_eval
    import bowling_pkg::*;
(
    input  pin_t       a,
    input  pin_t       b,
    input  pin_t       c,
    output logic [4:0] frame_points,
    output logic [1:0] idx_step
);
    logic [4:0] ab;
    logic       strike;
    logic       spare;
    // strike takes two bonus rolls, spare takes one, open frame just sums its two rolls
    always_comb begin
        ab           = 5'(a) + 5'(b);
        strike       = a == PIN_W'(STRIKE_PINS);
        spare        = ab == 5'(STRIKE_PINS);
        frame_points = strike ? 5'(STRIKE_PINS) + 5'(b) + 5'(c) :
                       spare  ? 5'(STRIKE_PINS) + 5'(c) : ab;
        idx_step     = strike ? 2'd1 : 2'd2;
    end
endmodule

// File: rtl/bowling_scorer.sv
// bowling_scorer: records up to 21 rolls and scores the game one frame per clock on request
module bowling_scorer
    import bowling_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               roll,
    input  logic               calculate_score,
    input  logic [PIN_W-1:0]   pin_count,
    output logic [SCORE_W-1:0] score
);
    localparam logic [5:0] LIM        = 6'(MAX_ROLLS);
    localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES - 1);
    state_t     state, next_state;
    pin_t       rolls [MAX_ROLLS];
    logic [4:0] roll_count;
    logic [4:0] idx;
    logic [3:0] frame;
    score_t     acc;
    pin_t       pin_in, a, b, c;
    logic [5:0] i0, i1, i2;
    logic [4:0] frame_points;
    logic [1:0] idx_step;
    logic       capture;
    // clamp over-range pin counts and fetch the frame's rolls, reading past the end as zero
    always_comb begin
        pin_in  = (pin_count > PIN_W'(STRIKE_PINS)) ? PIN_W'(STRIKE_PINS) : pin_count;
        capture = state == IDLE && roll && {1'b0, roll_count} < LIM;
        i0      = {1'b0, idx};
        i1      = i0 + 6'd1;
        i2      = i0 + 6'd2;
        a       = (i0 < LIM) ? rolls[i0[4:0]] : '0;
        b       = (i1 < LIM) ? rolls[i1[4:0]] : '0;
        c       = (i2 < LIM) ? rolls[i2[4:0]] : '0;
    end
    bowling_frame_eval u_eval (
        .a            (a),
        .b            (b),
        .c            (c),
        .frame_points (frame_points),
        .idx_step     (idx_step)
    );
    // roll storage: only written while idle, saturating at a full game
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_ROLLS; i++) rolls[i] <= '0;
            roll_count <= '0;
        end else if (capture) begin
            rolls[roll_count] <= pin_in;
            roll_count        <= roll_count + 5'd1;
        end
    end
    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end
    // next state: a scoring run always completes, and DONE waits for the request to drop
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = calculate_score ? SCORING : IDLE;
            SCORING: next_state = (frame == LAST_FRAME) ? DONE : SCORING;
            DONE:    next_state = calculate_score ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end
    // scoring walk: the start edge clears, each scoring cycle adds one frame
    always_ff @(posedge clock) begin
        if (reset) begin
            acc   <= '0;
            frame <= '0;
            idx   <= '0;
        end else if (state == IDLE && calculate_score) begin
            acc   <= '0;
            frame <= '0;
            idx   <= '0;
        end else if (state == SCORING) begin
            acc   <= acc + SCORE_W'(frame_points);
            frame <= frame + 4'd1;
            idx   <= idx + 5'(idx_step);
        end
    end
    assign score = acc;
endmodule

// File: tb/tb_bowling_scorer.sv
// tb_bowling_scorer: directed and random games checked against a frame-rule reference model
module tb_bowling_scorer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       roll = 1'b0;
    logic       calculate_score = 1'b0;
    logic [3:0] pin_count = '0;
    logic [8:0] score;
    int checks = 0;
    int errors = 0;
    int mr [25];
    int mcount = 0;

    bowling_scorer dut (
        .clock           (clock),
        .reset           (reset),
        .roll            (roll),
        .calculate_score (calculate_score),
        .pin_count       (pin_count),
        .score           (score)
    );

    always #5 clock = ~clock;

    function automatic int model(input int nf);
        int i = 0;
        int t = 0;
        for (int f = 0; f < nf; f++) begin
            if (mr[i] == 10) begin
                t += 10 + mr[i+1] + mr[i+2];
                i += 1;
            end else if (mr[i] + mr[i+1] == 10) begin
                t += 10 + mr[i+2];
                i += 2;
            end else begin
                t += mr[i] + mr[i+1];
                i += 2;
            end
        end
        return t;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        roll = 1'b0;
        calculate_score = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 25; i++) mr[i] = 0;
        mcount = 0;
    endtask

    task automatic do_roll(input int p);
        roll = 1'b1;
        pin_count = 4'(p);
        @(posedge clock);
        #1 roll = 1'b0;
        if (mcount < 21) mr[mcount] = (p > 10) ? 10 : p;
        mcount++;
    endtask

    task automatic do_score(input string tag, input bit poke, input int extra_hold);
        calculate_score = 1'b1;
        @(posedge clock);
        #1;
        if (poke) begin
            roll = 1'b1;
            pin_count = 4'd10;
        end
        repeat (10) @(posedge clock);
        #1 check(tag, score, model(10));
        if (extra_hold > 0) begin
            repeat (extra_hold) @(posedge clock);
            #1 check({tag, "_hold"}, score, model(10));
        end
        calculate_score = 1'b0;
        @(posedge clock);
        #1 roll = 1'b0;
    endtask

    initial begin
        do_reset();
        #1 check("reset", score, 0);
        do_score("empty", 1'b0, 0);

        do_reset();
        do_roll(8);
        repeat (19) do_roll(0);
        do_score("open8", 1'b0, 0);
        check("open8_val", score, 8);

        do_reset();
        repeat (3) do_roll(5);
        repeat (17) do_roll(0);
        do_score("spare", 1'b0, 0);
        check("spare_val", score, 20);

        do_reset();
        do_roll(10);
        do_roll(3);
        do_roll(4);
        repeat (16) do_roll(0);
        do_score("strike", 1'b0, 0);
        check("strike_val", score, 24);

        do_reset();
        repeat (12) do_roll(10);
        do_score("perfect", 1'b0, 20);
        check("perfect_val", score, 300);
        do_roll(7);
        @(posedge clock);
        #1 check("roll_keeps_score", score, 300);
        do_reset();
        #1 check("perfect_reset", score, 0);

        do_reset();
        do_roll(8);
        do_score("roll_ignored_scoring", 1'b1, 0);
        do_score("roll_ignored_rescore", 1'b0, 0);
        check("roll_ignored_val", score, 8);

        do_reset();
        do_roll(15);
        do_roll(3);
        do_score("clamp", 1'b0, 0);
        check("clamp_val", score, 16);

        do_reset();
        repeat (25) do_roll(4);
        do_score("saturate", 1'b0, 0);
        check("saturate_val", score, 80);

        do_reset();
        repeat (3) do_roll(4);
        calculate_score = 1'b1;
        @(posedge clock);
        repeat (5) @(posedge clock);
        #1 check("partial5", score, model(5));
        reset = 1'b1;
        calculate_score = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        check("mid_reset", score, 0);
        for (int i = 0; i < 25; i++) mr[i] = 0;
        mcount = 0;
        repeat (20) do_roll(1);
        do_score("rescore", 1'b0, 0);
        check("rescore_val", score, 20);

        for (int g = 0; g < 25; g++) begin
            int n;
            do_reset();
            n = $urandom_range(0, 23);
            for (int r = 0; r < n; r++) begin
                int k;
                k = $urandom_range(0, 5);
                do_roll(k == 0 ? 10 : k == 1 ? (10 - (mcount < 21 ? mr[mcount-(mcount>0)] : 0)) : $urandom_range(0, 12));
            end
            do_score($sformatf("random%0d", g), 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
